// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// IF-stage fetch port and the MEM-stage load/store port.
// The data port has priority. A fetch that is waiting when a data access
// completes is always served next, with no idle cycle in between.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort transactions that
// see no m_ack within TIMEOUT cycles and raise the sticky err flag.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t state_r;
    logic   d_elig_s;
    logic   if_elig_s;
    logic   timeout_s;

    // A requester cannot be granted again in the cycle its ready pulse is high.
    assign d_elig_s  = d_req & ~d_ready;
    assign if_elig_s = if_req & ~if_ready;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_r;
    logic          err_r;

    // The abort fires on the TIMEOUT-th busy cycle that sees no acknowledge.
    assign timeout_s = (state_r != IDLE) && !m_ack &&
                       (wait_cnt_r == CW'(TIMEOUT - 1));
    assign err       = err_r;

    // Wait counter restarts on every grant; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
            err_r      <= 1'b0;
        end else if (state_r == IDLE || m_ack || timeout_s) begin
            wait_cnt_r <= '0;
            err_r      <= err_r | timeout_s;
        end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
            err_r      <= err_r;
        end
    end
`else
    logic unused_timeout_s;

    assign unused_timeout_s = TIMEOUT[0];
    assign timeout_s        = 1'b0;
    assign err              = 1'b0;
`endif

    // Arbitration FSM: owns every registered output of the memory bus and both ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (d_elig_s) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        state_r <= DATA;
                    end else if (if_elig_s) begin
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        state_r <= FETCH;
                    end else begin
                        m_req   <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                DATA: begin
                    if (m_ack) begin
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                        d_ready <= 1'b1;
                        // A waiting fetch goes next so it never waits longer than one data access.
                        if (if_elig_s) begin
                            m_we    <= 1'b0;
                            m_addr  <= if_addr;
                            state_r <= FETCH;
                        end else begin
                            m_req   <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else if (timeout_s) begin
                        d_rdata <= '0;
                        d_ready <= 1'b1;
                        m_req   <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DATA;
                    end
                end
                FETCH: begin
                    if (m_ack) begin
                        if_rdata <= m_rdata;
                        if_ready <= 1'b1;
                        if (d_elig_s) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            state_r <= DATA;
                        end else begin
                            m_req   <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else if (timeout_s) begin
                        if_rdata <= '0;
                        if_ready <= 1'b1;
                        m_req    <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                default: begin
                    m_req   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a simple latency-programmable
// memory responder that logs the address of every acknowledged transaction.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;

    int          n_checks;
    int          n_pass;
    int          lat;
    bit          mem_en;
    int          cnt;
    logic [31:0] log_addr [16];
    int          log_n;
    int          ncyc;
    int          nbad;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2002_000A;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory responder: acknowledges lat cycles after it sees m_req.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_ack = 1'b0;
            cnt   = 0;
        end else if (m_ack) begin
            m_ack = 1'b0;
            cnt   = 0;
        end else if (m_req && mem_en) begin
            cnt = cnt + 1;
            if (cnt >= lat) begin
                m_ack   = 1'b1;
                m_rdata = mem_model(m_addr);
                if (log_n < 16) log_addr[log_n] = m_addr;
                log_n = log_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a ready pulse; counts cycles and cycles the port
    // was not stalled, and checks m_req stays high if asked to.
    task automatic wait_ready(input bit is_data, input bit need_mreq, output int n, output int bad);
        bit seen;
        n    = 0;
        bad  = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n = n + 1;
            seen = is_data ? d_ready : if_ready;
            if (!seen && !(is_data ? stall_mem : stall_if)) bad = bad + 1;
            if (need_mreq && !m_req) bad = bad + 1;
        end
        check(is_data ? "d_ready_seen" : "if_ready_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        lat      = 3;
        mem_en   = 1'b1;
        cnt      = 0;
        log_n    = 0;
        m_ack    = 1'b0;
        m_rdata  = 32'h0;
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single fetch, memory latency 3
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        #1;
        check("t1_stall_if", {31'd0, stall_if}, 32'd1);
        @(negedge clk);
        check("t1_m_req", {31'd0, m_req}, 32'd1);
        check("t1_m_addr", m_addr, 32'h0000_0040);
        wait_ready(1'b0, 1'b0, ncyc, nbad);
        check("t1_latency", ncyc, 32'd3);
        check("t1_stall_gap", nbad, 32'd0);
        check("t1_if_rdata", if_rdata, 32'h2002_000A);
        check("t1_stall_end", {31'd0, stall_if}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);

        // 2: simultaneous load and fetch; data first, fetch follows without a bubble
        lat    = 2;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0100;
        if_req = 1'b1;
        if_addr = 32'h0000_0044;
        @(negedge clk);
        check("t2_grant_data", m_addr, 32'h0000_0100);
        wait_ready(1'b1, 1'b1, ncyc, nbad);
        check("t2_mreq_cont", nbad, 32'd0);
        check("t2_d_rdata", d_rdata, 32'hA5A5_0100);
        check("t2_m_addr_fetch", m_addr, 32'h0000_0044);
        check("t2_m_req", {31'd0, m_req}, 32'd1);
        d_req = 1'b0;
        wait_ready(1'b0, 1'b0, ncyc, nbad);
        check("t2_if_rdata", if_rdata, 32'hA5A5_0044);
        if_req = 1'b0;
        @(negedge clk);

        // 3: continuous loads and fetches; order DATA, FETCH, DATA, FETCH
        log_n   = 0;
        d_req   = 1'b1;
        d_addr  = 32'h0000_0100;
        if_req  = 1'b1;
        if_addr = 32'h0000_0048;
        wait_ready(1'b1, 1'b0, ncyc, nbad);
        d_addr = 32'h0000_0104;
        wait_ready(1'b0, 1'b0, ncyc, nbad);
        check("t3_if_rdata", if_rdata, 32'hA5A5_0048);
        check("t3_regrant_data", m_addr, 32'h0000_0104);
        if_addr = 32'h0000_004C;
        wait_ready(1'b1, 1'b0, ncyc, nbad);
        check("t3_d_rdata", d_rdata, 32'hA5A5_0104);
        check("t3_regrant_fetch", m_addr, 32'h0000_004C);
        d_req = 1'b0;
        wait_ready(1'b0, 1'b0, ncyc, nbad);
        if_req = 1'b0;
        @(negedge clk);
        check("t3_log_n", log_n, 32'd4);
        check("t3_order0", log_addr[0], 32'h0000_0100);
        check("t3_order1", log_addr[1], 32'h0000_0048);
        check("t3_order2", log_addr[2], 32'h0000_0104);
        check("t3_order3", log_addr[3], 32'h0000_004C);
        check("t3_idle", {31'd0, m_req}, 32'd0);

        // 4: store leaves d_rdata untouched
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0104;
        d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t4_m_we", {31'd0, m_we}, 32'd1);
        check("t4_m_wdata", m_wdata, 32'hDEAD_BEEF);
        wait_ready(1'b1, 1'b0, ncyc, nbad);
        check("t4_d_rdata_kept", d_rdata, 32'hA5A5_0104);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);

        // 5: reset in the middle of a data access
        lat    = 10;
        d_req  = 1'b1;
        d_addr = 32'h0000_0200;
        repeat (3) @(negedge clk);
        check("t5_busy", {31'd0, m_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_m_req_drop", {31'd0, m_req}, 32'd0);
        check("t5_m_addr_clr", m_addr, 32'h0);
        d_req = 1'b0;
        nbad  = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_ready || if_ready) nbad = nbad + 1;
        end
        check("t5_no_ready", nbad, 32'd0);
        rst_n   = 1'b1;
        lat     = 2;
        if_req  = 1'b1;
        if_addr = 32'h0000_0060;
        wait_ready(1'b0, 1'b0, ncyc, nbad);
        check("t5_if_rdata", if_rdata, 32'hA5A5_0060);
        if_req = 1'b0;
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: fetch never acknowledged -> abort on the 16th wait cycle
        mem_en  = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        @(negedge clk);
        check("t6_m_req", {31'd0, m_req}, 32'd1);
        wait_ready(1'b0, 1'b0, ncyc, nbad);
        check("t6_wait", ncyc, 32'd16);
        check("t6_if_rdata", if_rdata, 32'h0);
        check("t6_m_req_drop", {31'd0, m_req}, 32'd0);
        check("t6_err", {31'd0, err}, 32'd1);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_err_sticky", {31'd0, err}, 32'd1);
        mem_en = 1'b1;
`else
        check("err_tied", {31'd0, err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
